// File: rtl/bf_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep stage.
package bf_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int HOLD_W = 8;
  localparam int GRAY_W = 8;

  function automatic logic [GRAY_W-1:0] gray_of(input logic [GRAY_W-1:0] value);
    return value ^ (value >> 1);
  endfunction

endpackage

// File: rtl/bf_truth_sweep_if.sv
// Bus between the sweep stage (slave) and the function block / checker side (master).
interface bf_truth_sweep_if #(
  parameter int N_IN = 3
);
  // Handshake: start is a request taken only while the stage is idle (busy low,
  // done low); it is never queued. done is a single-cycle completion pulse, and
  // truth_d/truth_e are valid from the done cycle until the next accepted start.
  logic                 start;
  logic [N_IN-1:0]      in_vec;
  logic                 d_i;
  logic                 e_i;
  logic                 busy;
  logic                 done;
  logic [2**N_IN-1:0]   truth_d;
  logic [2**N_IN-1:0]   truth_e;

  modport master (
    output start, d_i, e_i,
    input  in_vec, busy, done, truth_d, truth_e
  );

  modport slave (
    input  start, d_i, e_i,
    output in_vec, busy, done, truth_d, truth_e
  );
endinterface

// File: rtl/bf_hold_timer.sv
// Hold-window timer: counts enabled cycles and pulses tc on the last cycle of each window.
module bf_hold_timer
  import bf_sweep_pkg::*;
#(
  parameter int HOLD_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [HOLD_W-1:0] LAST = HOLD_W'(HOLD_CYC - 1);

  logic [HOLD_W-1:0] count;

  assign tc = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + HOLD_W'(1);
    end
  end

endmodule

// File: rtl/bf_truth_sweep.sv
// Synchronous truth-table sweep around a 3-input boolean block.
// Build option GRAY_ORDER_EN: drive patterns in Gray order instead of binary order.
module bf_truth_sweep
  import bf_sweep_pkg::*;
#(
  parameter int N_IN     = 3,
  parameter int HOLD_CYC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  bf_truth_sweep_if.slave    bus,
  output state_t             state_dbg
);

  localparam int              NPAT = 2**N_IN;
  localparam logic [N_IN-1:0] LAST = '1;

  state_t            state;
  state_t            next_state;
  logic [N_IN-1:0]   pattern;
  logic [N_IN-1:0]   drive_val;
  logic [NPAT-1:0]   truth_d_q;
  logic [NPAT-1:0]   truth_e_q;
  logic              hold_clr;
  logic              hold_en;
  logic              hold_tc;
  logic              launch;
  logic              busy;
  logic              done;
  logic [N_IN-1:0]   in_vec;

  // Capture index is the value actually driven, so results keep binary-index meaning.
`ifdef GRAY_ORDER_EN
  assign drive_val = N_IN'(gray_of(GRAY_W'(pattern)));
`else
  assign drive_val = pattern;
`endif

  bf_hold_timer #(
    .HOLD_CYC (HOLD_CYC)
  ) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (hold_clr),
    .en    (hold_en),
    .tc    (hold_tc)
  );

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    in_vec     = '0;
    hold_clr   = 1'b0;
    hold_en    = 1'b0;
    launch     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          next_state = DRIVE;
          hold_clr   = 1'b1;
          launch     = 1'b1;
        end
      end
      DRIVE: begin
        busy    = 1'b1;
        hold_en = 1'b1;
        in_vec  = drive_val;
        if (hold_tc && (pattern == LAST)) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pattern   <= '0;
      truth_d_q <= '0;
      truth_e_q <= '0;
    end else begin
      state <= next_state;
      if (launch) begin
        pattern   <= '0;
        truth_d_q <= '0;
        truth_e_q <= '0;
      end else if ((state == DRIVE) && hold_tc) begin
        truth_d_q[drive_val] <= bus.d_i;
        truth_e_q[drive_val] <= bus.e_i;
        if (pattern != LAST) pattern <= pattern + N_IN'(1);
      end
    end
  end

  assign bus.in_vec  = in_vec;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.truth_d = truth_d_q;
  assign bus.truth_e = truth_e_q;
  assign state_dbg   = state;

endmodule

// File: doc/bf_truth_sweep.md
Name: bf_truth_sweep

Overview:
Clocked stimulus and capture stage wrapped around the 3-input boolean-function block (BF2: inputs A/B/C, outputs D/E).
- Replaces free-running testbench toggling with a synchronous sweep.
- Drives every input pattern in turn, holds each for a programmable time, and samples D and E at the end of each hold window.
- Assembles full truth-table vectors for readout by later checker/display stages.

Parameters:
N_IN, 3, number of function inputs; 2**N_IN patterns per sweep
HOLD_CYC, 4, clock cycles each pattern is held on in_vec (legal range 1..255)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  synchronous active-low reset
start  input  1  sweep request; sampled only in IDLE
in_vec  output  N_IN  drives the function inputs; bit0=A, bit1=B, bit2=C
d_i  input  1  function output D
e_i  input  1  function output E
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse when the sweep completes
truth_d  output  2**N_IN  captured D per pattern; bit k = D when in_vec==k
truth_e  output  2**N_IN  captured E per pattern; bit k = E when in_vec==k

Behaviour:
- Reset: rst_n sampled low at a clk edge forces:
  - state=IDLE, in_vec=0, busy=0, done=0
  - truth_d=0, truth_e=0
  - pattern counter=0, hold counter=0
- Reset applies in every state. Reset mid-sweep aborts the sweep with no done pulse and clears partial results.
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - in_vec=0, busy=0.
  - start=1 at edge T → DRIVE at T+1.
  - At the same edge: truth_d/truth_e cleared, pattern=0, hold=0.
- DRIVE:
  - busy=1, in_vec=pattern. hold increments each cycle.
  - When hold==HOLD_CYC-1, the next edge captures d_i→truth_d[pattern] and e_i→truth_e[pattern], and resets hold to 0.
  - At that same edge, if pattern==2**N_IN-1, go to DONE; otherwise pattern increments.
- Each pattern is therefore presented for exactly HOLD_CYC cycles. Sampling at the window end gives the combinational function HOLD_CYC-1 cycles of settle margin.
- DONE:
  - Lasts one cycle: done=1, busy=0, in_vec returns to 0. Then unconditional return to IDLE.
- Latency: start accepted at edge T → done high in cycle T+1+(2**N_IN)*HOLD_CYC. busy is high for exactly (2**N_IN)*HOLD_CYC cycles.
- start while busy or in DONE is ignored; it is not queued. start held high continuously re-launches a sweep from each IDLE cycle, so the period is (2**N_IN)*HOLD_CYC+2 cycles.
- HOLD_CYC=1: a new pattern every cycle, and each sample is taken in the same cycle the pattern is applied.
- truth_d/truth_e hold their values after DONE until the next accepted start or reset.
- Counter widths: pattern is N_IN bits and does not wrap within a sweep; hold is 8 bits.

Optional Feature:
GRAY_ORDER_EN
- Defined: in DRIVE, in_vec = pattern ^ (pattern>>1), i.e. Gray order with one input changing per step. Capture index is the Gray value actually driven, so truth_d/truth_e keep binary-index meaning.
- Undefined: binary order as above.
- Final truth vectors are identical either way; only the drive order differs.

Decomposition:
- Package bf_sweep_pkg:
  - state enum typedef (IDLE, DRIVE, DONE)
  - HOLD_W=8
  - function gray_of(value)
- One sub-module, bf_hold_timer:
  - inputs: clk, rst_n, clr, en
  - output: terminal-count pulse when the count reaches HOLD_CYC-1
- The FSM, pattern counter and capture registers stay in the top.

Test Plan:
- Bench model D=A^B^C, E=majority(A,B,C); HOLD_CYC=4; one start pulse → busy for 32 cycles, done pulse at cycle 33 after acceptance, truth_d=8'h96, truth_e=8'hE8.
- Model D=A&~C, E=~B → truth_d=8'h0A, truth_e=8'h33; in_vec sequence 0..7, each value held exactly 4 cycles.
- start pulsed again at busy cycles 5 and 20 → ignored, single done pulse, results unchanged from the single-start case.
- rst_n low for 1 cycle at busy cycle 10 → next cycle state IDLE, busy=0, truth_d=truth_e=0, no done pulse; a fresh start completes normally.
- HOLD_CYC=1 with the parity model → busy 8 cycles, truth_d=8'h96; start held high → done pulses every 10 cycles.
- GRAY_ORDER_EN defined → in_vec sequence 0,1,3,2,6,7,5,4; truth vectors identical to the binary run for both models.
